// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with busy scoreboard, conflict flag and optional write-to-read bypass
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec,
    output logic                wr_conflict
);
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             conf_q, conf_d;
    logic [AW-1:0]    wa [NWR];
    logic [NWR-1:0]   wv;
    logic [AW-1:0]    ra [NRD];
    logic [NRD-1:0]   hit;
    logic [XLEN-1:0]  byp [NRD];

    function automatic logic ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !(ZERO_REG != 0 && a == '0);
    endfunction

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        conf_d = 1'b0;
        wv     = '0;
        for (int w = 0; w < NWR; w++) begin
            wa[w] = wr_addr[w*AW +: AW];
            wv[w] = wr_en[w] && ok(wa[w]);
        end
        // later ports overwrite earlier ones, so the highest index wins
        for (int w = 0; w < NWR; w++) begin
            if (wv[w]) begin
                regs_d[wa[w]] = wr_data[w*XLEN +: XLEN];
                busy_d[wa[w]] = 1'b0;
            end
        end
        for (int i = 0; i < NWR; i++)
            for (int j = i + 1; j < NWR; j++)
                if (wv[i] && wv[j] && wa[i] == wa[j]) conf_d = 1'b1;
        if (iss_en && ok(iss_addr)) busy_d[iss_addr] = 1'b1;
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        hit     = '0;
        for (int k = 0; k < NRD; k++) begin
            ra[k]  = rd_addr[k*AW +: AW];
            byp[k] = '0;
            for (int w = 0; w < NWR; w++) begin
                if (wv[w] && wa[w] == ra[k]) begin
                    hit[k] = 1'b1;
                    byp[k] = wr_data[w*XLEN +: XLEN];
                end
            end
            rd_data[k*XLEN +: XLEN] = (rst || !ok(ra[k])) ? '0 :
                                      (BYPASS != 0 && hit[k]) ? byp[k] : regs_q[ra[k]];
            rd_busy[k] = !rst && ok(ra[k]) && busy_q[ra[k]] && !(BYPASS != 0 && hit[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            busy_q <= '0;
            conf_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            conf_q <= conf_d;
        end
    end

    assign busy_vec    = busy_q;
    assign wr_conflict = conf_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of reg_file_mp (bypass and non-bypass instances) through an expectation queue
module tb_reg_file_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic [31:0] busy_vec, busy_vec_nb;
    logic        wr_conflict, wr_conflict_nb;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t q[$];

    reg_file_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .busy_vec(busy_vec), .wr_conflict(wr_conflict)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .busy_vec(busy_vec_nb), .wr_conflict(wr_conflict_nb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sel: 0/1 rd_data port, 2/3 rd_busy port, 4 busy_vec, 5 wr_conflict, 6 rd_data port0 no-bypass, 7 rd_busy port0 no-bypass
    function automatic logic [31:0] act(input int sel);
        case (sel)
            0: return rd_data[31:0];
            1: return rd_data[63:32];
            2: return {31'b0, rd_busy[0]};
            3: return {31'b0, rd_busy[1]};
            4: return busy_vec;
            5: return {31'b0, wr_conflict};
            6: return rd_data_nb[31:0];
            7: return {31'b0, rd_busy_nb[0]};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = act(e.sel);
            checks++;
            if (a !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, a, e.exp, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    task automatic expect_v(input int sel, input logic [31:0] v, input string name);
        q.push_back('{cyc, sel, v, name});
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        tick();
        rd(5, 9);
        expect_v(0, 0, "reset_rd0");
        expect_v(4, 0, "reset_busy_vec");
        expect_v(5, 0, "reset_conflict");
        tick();
        rst = 1'b0;
        wr(0, 5, 32'hDEADBEEF); rd(5, 5);
        expect_v(0, 32'hDEADBEEF, "bypass_r5_same_cycle");
        expect_v(6, 0, "nobypass_r5_same_cycle");
        tick();
        rd(5, 5);
        expect_v(0, 32'hDEADBEEF, "r5_port0");
        expect_v(1, 32'hDEADBEEF, "r5_port1");
        expect_v(6, 32'hDEADBEEF, "nobypass_r5_next");
        tick();
        wr(0, 0, 32'h1); rd(0, 0);
        expect_v(0, 0, "r0_bypass_ignored");
        tick();
        expect_v(1, 0, "r0_reads_zero");
        expect_v(6, 0, "nobypass_r0_zero");
        tick();
        wr(1, 7, 32'h1234); rd(7, 5);
        expect_v(0, 32'h1234, "bypass_r7");
        expect_v(6, 0, "nobypass_r7_old");
        tick();
        rd(7, 5);
        expect_v(6, 32'h1234, "nobypass_r7_next");
        tick();
        wr(0, 3, 32'hAAAA); wr(1, 3, 32'h5555); rd(3, 3);
        expect_v(0, 32'h5555, "conflict_bypass_winner");
        expect_v(5, 0, "conflict_not_yet");
        tick();
        expect_v(1, 32'h5555, "conflict_r3_stored");
        expect_v(6, 32'h5555, "nobypass_r3_stored");
        expect_v(5, 1, "conflict_pulse");
        tick();
        expect_v(5, 0, "conflict_one_cycle");
        tick();
        iss_en = 1'b1; iss_addr = 9; rd(9, 9);
        expect_v(2, 0, "iss_busy_not_yet");
        expect_v(4, 0, "iss_busy_vec_not_yet");
        tick();
        rd(9, 5);
        expect_v(2, 1, "rd_busy_r9");
        expect_v(3, 0, "rd_busy_r5_clear");
        expect_v(4, 32'h200, "busy_vec_r9");
        tick();
        wr(0, 9, 32'd99); rd(9, 9);
        expect_v(2, 0, "rd_busy_bypass_forced");
        expect_v(7, 1, "nobypass_rd_busy_kept");
        expect_v(4, 32'h200, "busy_vec_before_edge");
        tick();
        expect_v(4, 0, "busy_vec_cleared");
        expect_v(0, 32'd99, "r9_written");
        tick();
        iss_en = 1'b1; iss_addr = 9;
        tick();
        iss_en = 1'b1; iss_addr = 9; wr(1, 9, 32'd5);
        expect_v(4, 32'h200, "busy_vec_reissued");
        tick();
        expect_v(4, 32'h200, "set_beats_clear");
        tick();
        iss_en = 1'b1; iss_addr = 0;
        tick();
        rd(0, 0);
        expect_v(4, 32'h200, "iss_r0_ignored");
        expect_v(2, 0, "rd_busy_r0");
        wr(0, 3, 32'h1); wr(1, 3, 32'h2);
        tick();
        rst = 1'b1; rd(5, 9);
        wr(0, 5, 32'h77);
        iss_en = 1'b1; iss_addr = 4;
        expect_v(0, 0, "midreset_r5");
        expect_v(3, 0, "midreset_rd_busy_r9");
        expect_v(4, 0, "midreset_busy_vec");
        expect_v(5, 0, "midreset_conflict");
        tick();
        rst = 1'b0; rd(5, 3);
        expect_v(0, 0, "after_reset_r5");
        expect_v(1, 0, "after_reset_r3");
        expect_v(4, 0, "after_reset_busy");
        tick();
        tick();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
